// File: rtl/shiftregbit_pkg.sv
// Shared types and helpers for the parallel-in serial-out bit transmitter.
// Optional feature macro: SHIFTREGBIT_TX_PARITY_EN (appends one parity beat per word).
package shiftregbit_pkg;

    // PARITY is always declared so the encoding is identical in every build;
    // it is only reachable when the parity beat is compiled in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } tx_state_t;

    // Number of serial beats used to carry one W-bit word.
    function automatic int beats_per_word(input int w);
`ifdef SHIFTREGBIT_TX_PARITY_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

endpackage

// File: rtl/shiftregbit_tx_holdbuf.sv
// One-entry hold register: parks a word accepted while the shifter is busy.
// Only the occupancy flag is reset; the payload is meaningless while empty.
module tx_holdbuf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         valid
);

    logic [W-1:0] data_q;
    logic         valid_q;
    logic         valid_d;

    // Occupancy: a write fills the slot, a read empties it (never both at once,
    // since writes need an empty slot and reads need a full one).
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d = 1'b1;
        end else if (rd_en) begin
            valid_d = 1'b0;
        end
    end

    // Occupancy flag register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload capture; no reset needed because valid_q gates its use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q <= wr_data;
        end
    end

    assign rd_data = data_q;
    assign valid   = valid_q;

endmodule

// File: rtl/shiftregbit_tx.sv
// Parallel-in serial-out transmitter: takes a W-bit word on a valid/ready
// port and streams it MSB first, one bit per beat, on a valid/ready serial port.
// A one-entry hold buffer lets the next word wait so words stream gaplessly.
// Optional feature macro: SHIFTREGBIT_TX_PARITY_EN (adds an even-XOR parity
// beat after the W data beats of every word).
module shiftregbit_tx
    import shiftregbit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    tx_state_t    state_q, state_d;
    logic [W-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef SHIFTREGBIT_TX_PARITY_EN
    logic         p_q, p_d;
`endif

    logic         accept;
    logic         beat;
    logic         last;
    logic         hb_wr;
    logic         hb_rd;
    logic         hvalid;
    logic [W-1:0] hdata;

    assign in_ready  = !hvalid;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != IDLE);
    assign beat      = out_valid && out_ready;
    assign busy      = (state_q != IDLE) || hvalid;

    // The word ends on the final beat: the parity beat when enabled,
    // otherwise the last data beat.
`ifdef SHIFTREGBIT_TX_PARITY_EN
    assign last = beat && (state_q == PARITY);
`else
    assign last = beat && (state_q == SHIFT) && (cnt_q == CNT_ONE);
`endif

    // A word arriving while busy is parked unless it can be bypassed straight
    // into the shifter on the final beat; the parked word is drained first.
    assign hb_wr = accept && (state_q != IDLE) && !last;
    assign hb_rd = last && hvalid;

    tx_holdbuf #(
        .W(W)
    ) u_holdbuf (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (hb_wr),
        .wr_data(in_data),
        .rd_en  (hb_rd),
        .rd_data(hdata),
        .valid  (hvalid)
    );

    // Serial bit mux: data MSB while shifting, parity bit on the parity beat.
    always_comb begin
        case (state_q)
            SHIFT:   out_b = sr_q[W-1];
`ifdef SHIFTREGBIT_TX_PARITY_EN
            PARITY:  out_b = p_q;
`endif
            default: out_b = 1'b0;
        endcase
    end

    // Next-state: load, shift, and end-of-word reload/idle decision.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef SHIFTREGBIT_TX_PARITY_EN
        p_d     = p_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = in_data;
                    cnt_d   = CNT_FULL;
                    state_d = SHIFT;
`ifdef SHIFTREGBIT_TX_PARITY_EN
                    p_d     = ^in_data;
`endif
                end
            end
            SHIFT: begin
                if (beat && (cnt_q > CNT_ONE)) begin
                    sr_d  = sr_q << 1;
                    cnt_d = cnt_q - CNT_ONE;
                end
`ifdef SHIFTREGBIT_TX_PARITY_EN
                else if (beat) begin
                    sr_d    = sr_q << 1;
                    cnt_d   = '0;
                    state_d = PARITY;
                end
`endif
            end
            default: begin
`ifndef SHIFTREGBIT_TX_PARITY_EN
                state_d = IDLE;
`endif
            end
        endcase

        // End of word: held word first, then a same-cycle arrival, else idle.
        if (last) begin
            if (hvalid) begin
                sr_d    = hdata;
                cnt_d   = CNT_FULL;
                state_d = SHIFT;
`ifdef SHIFTREGBIT_TX_PARITY_EN
                p_d     = ^hdata;
`endif
            end else if (accept) begin
                sr_d    = in_data;
                cnt_d   = CNT_FULL;
                state_d = SHIFT;
`ifdef SHIFTREGBIT_TX_PARITY_EN
                p_d     = ^in_data;
`endif
            end else begin
                sr_d    = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        end
    end

    // Transmitter state registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
`ifdef SHIFTREGBIT_TX_PARITY_EN
            p_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
`ifdef SHIFTREGBIT_TX_PARITY_EN
            p_q     <= p_d;
`endif
        end
    end

endmodule

// File: tb/tb_shiftregbit_tx.sv
// Self-checking bench for shiftregbit_tx: a W=8 and a W=1 instance, each
// checked every cycle against a bit-queue model of the serial stream.
module tb_shiftregbit_tx;

`ifdef SHIFTREGBIT_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int BPW8 = 8 + PB;
    localparam int BPW1 = 1 + PB;

    logic       clk = 1'b0;
    logic       rst;
    logic       v8, rdy8, b8, ov8, ordy8, busy8;
    logic [7:0] d8;
    logic       v1, rdy1, b1, ov1, ordy1, busy1;
    logic [0:0] d1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    shiftregbit_tx #(.W(8)) u8 (
        .clk(clk), .reset(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
        .out_b(b8), .out_valid(ov8), .out_ready(ordy8), .busy(busy8)
    );

    shiftregbit_tx #(.W(1)) u1 (
        .clk(clk), .reset(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .out_b(b1), .out_valid(ov1), .out_ready(ordy1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of bits still owed on the serial port.
    bit   q8[$], q1[$];
    bit   rec8[$], rec1[$];
    int   rcy8[$], rcy1[$];
    logic acc8 = 0, bt8 = 0, bs8 = 0;
    logic acc1 = 0, bt1 = 0, bs1 = 0;

    task automatic push8(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) q8.push_back(d[i]);
        if (PB == 1) q8.push_back(^d);
    endtask

    task automatic push1(input logic [0:0] d);
        q1.push_back(d[0]);
        if (PB == 1) q1.push_back(d[0]);
    endtask

    // Compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            q8.delete(); q1.delete();
            acc8 = 0; bt8 = 0; acc1 = 0; bt1 = 0;
            chk("rst_ov8", ov8, 0);   chk("rst_busy8", busy8, 0);
            chk("rst_rdy8", rdy8, 1); chk("rst_b8", b8, 0);
            chk("rst_ov1", ov1, 0);   chk("rst_rdy1", rdy1, 1);
        end else begin
            chk("ov8", ov8, q8.size() != 0);
            chk("busy8", busy8, q8.size() != 0);
            chk("rdy8", rdy8, q8.size() <= BPW8);
            chk("b8", b8, (q8.size() != 0) ? q8[0] : 1'b0);
            chk("ov1", ov1, q1.size() != 0);
            chk("busy1", busy1, q1.size() != 0);
            chk("rdy1", rdy1, q1.size() <= BPW1);
            chk("b1", b1, (q1.size() != 0) ? q1[0] : 1'b0);
            acc8 = v8 & rdy8; bt8 = ov8 & ordy8; bs8 = b8;
            acc1 = v1 & rdy1; bt1 = ov1 & ordy1; bs1 = b1;
        end
    end

    // Advance the model on the clock: consume beats, then append accepted words.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (bt8 && q8.size() != 0) begin
                void'(q8.pop_front());
                rec8.push_back(bs8); rcy8.push_back(cyc);
            end
            if (acc8) push8(d8);
            if (bt1 && q1.size() != 0) begin
                void'(q1.pop_front());
                rec1.push_back(bs1); rcy1.push_back(cyc);
            end
            if (acc1) push1(d1);
        end
    end

    // Word k as seen by a chained serial-in register shifting toward the MSB.
    function automatic logic [7:0] word8(input int k);
        logic [7:0] s = '0;
        for (int i = 0; i < 8; i++) begin
            if (k * BPW8 + i < rec8.size()) s = {s[6:0], rec8[k * BPW8 + i]};
            else s = 8'hxx;
        end
        return s;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] d);
        int k = 0;
        v8 = 1'b1; d8 = d;
        @(negedge clk);
        while (!rdy8 && k < 100) begin k++; @(negedge clk); end
        if (k >= 100) chk("send8_timeout", 1, 0);
        @(posedge clk); #1;
        v8 = 1'b0;
    endtask

    task automatic send1(input logic [0:0] d);
        int k = 0;
        v1 = 1'b1; d1 = d;
        @(negedge clk);
        while (!rdy1 && k < 100) begin k++; @(negedge clk); end
        if (k >= 100) chk("send1_timeout", 1, 0);
        @(posedge clk); #1;
        v1 = 1'b0;
    endtask

    int pat[4] = '{1, 0, 0, 1};

    initial begin
        rst = 1'b1;
        v8 = 0; d8 = '0; ordy8 = 0;
        v1 = 0; d1 = '0; ordy1 = 0;
        idle(3);
        rst = 1'b0;

        // Single word 0xA5, first bit the cycle after acceptance.
        rec8.delete(); rcy8.delete();
        ordy8 = 1'b1;
        send8(8'hA5);
        @(negedge clk);
        chk("a5_first_valid", ov8, 1);
        chk("a5_first_bit", b8, 1);
        idle(12);
        chk("a5_word", word8(0), 8'hA5);
        chk("a5_nbeats", rec8.size(), BPW8);
        chk("a5_span", rcy8[BPW8-1] - rcy8[0], BPW8 - 1);
        chk("a5_idle_ov", ov8, 0);
        chk("a5_idle_busy", busy8, 0);

        // Back-to-back 0x3C, 0xF0 through the hold buffer, no gap.
        rec8.delete(); rcy8.delete();
        send8(8'h3C);
        send8(8'hF0);
        @(negedge clk);
        chk("b2b_inrdy_low", rdy8, 0);
        idle(24);
        chk("b2b_nbeats", rec8.size(), 2 * BPW8);
        chk("b2b_word0", word8(0), 8'h3C);
        chk("b2b_word1", word8(1), 8'hF0);
        chk("b2b_span", rcy8[2*BPW8-1] - rcy8[0], 2 * BPW8 - 1);

        // 0x81 with out_ready stalls.
        rec8.delete(); rcy8.delete();
        send8(8'h81);
        for (int i = 0; i < 40; i++) begin
            ordy8 = 1'(pat[i % 4]);
            idle(1);
        end
        ordy8 = 1'b1;
        idle(4);
        chk("stall_nbeats", rec8.size(), BPW8);
        chk("stall_word", word8(0), 8'h81);
        chk("stall_idle_ov", ov8, 0);

        // Asynchronous reset mid-word, then a fresh word.
        rec8.delete(); rcy8.delete();
        send8(8'hFF);
        begin
            int k = 0;
            @(negedge clk);
            while (rec8.size() < 3 && k < 50) begin k++; @(negedge clk); end
            if (k >= 50) chk("areset_wait_timeout", 1, 0);
        end
        #2 rst = 1'b1;
        #1;
        chk("areset_ov", ov8, 0);
        chk("areset_busy", busy8, 0);
        chk("areset_rdy", rdy8, 1);
        chk("areset_b", b8, 0);
        idle(2);
        rst = 1'b0;
        rec8.delete(); rcy8.delete();
        send8(8'h01);
        idle(12);
        chk("after_rst_nbeats", rec8.size(), BPW8);
        chk("after_rst_word", word8(0), 8'h01);

        // W=1: words 1,0,1 back-to-back.
        rec1.delete(); rcy1.delete();
        ordy1 = 1'b1;
        send1(1'b1);
        send1(1'b0);
        send1(1'b1);
        idle(6);
        chk("w1_nbeats", rec1.size(), 3 * BPW1);
        chk("w1_bit0", rec1[0], 1);
        chk("w1_bit1", rec1[BPW1], 0);
        chk("w1_bit2", rec1[2*BPW1], 1);
        chk("w1_span", rcy1[3*BPW1-1] - rcy1[0], 3 * BPW1 - 1);

`ifdef SHIFTREGBIT_TX_PARITY_EN
        rec8.delete(); rcy8.delete();
        send8(8'h07);
        idle(14);
        send8(8'h03);
        idle(14);
        chk("par_word07", word8(0), 8'h07);
        chk("par_bit07", rec8[8], 1);
        chk("par_word03", word8(1), 8'h03);
        chk("par_bit03", rec8[17], 0);
`endif

        // Randomized traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            v8 = 1'($urandom_range(0, 1));
            d8 = 8'($urandom);
            ordy8 = ($urandom_range(0, 3) != 0);
            v1 = 1'($urandom_range(0, 1));
            d1 = 1'($urandom);
            ordy1 = ($urandom_range(0, 3) != 0);
            idle(1);
        end
        v8 = 0; v1 = 0; ordy8 = 1; ordy1 = 1;
        idle(40);
        chk("drain_busy8", busy8, 0);
        chk("drain_busy1", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
